at_cmd_sequencer: RTL and testbench
===================================

Name: at_cmd_sequencer

Overview:
- Parametrised successor to the SMS initialisation FSM in the IOT module.
- Walks a table of NUM_CMDS AT commands: streams each command's bytes from the command ROM to the UART TX, then waits for the expected response code from the response parser.
- Retries on timeout or ERROR using an internal timeout counter; no external timer is needed.
- After initialisation, services new-SMS notifications by issuing the read command (last table entry) followed by the message number and CR.

Parameters:
NUM_CMDS, 4, table entries; 0..NUM_CMDS-2 are init commands, NUM_CMDS-1 is the read command (AT+CMGR=)
ADDR_W, 7, command ROM address width
LEN_W, 6, command length field width, in bytes
TIMEOUT_CYC, 50000, clk cycles allowed per response wait
MAX_RETRY, 3, resends allowed per command before error
CIDX_W, $clog2(NUM_CMDS), table index width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse that begins initialisation
msg_no  in  8  SMS slot number for the read command
cmd_idx  out  CIDX_W  current table index; drives the descriptor table
desc_base  in  ADDR_W  first ROM address of entry cmd_idx (combinational)
desc_len  in  LEN_W  byte count of entry cmd_idx, always >= 1
desc_rsp  in  3  expected response code of entry cmd_idx
addr  out  ADDR_W  command ROM address
rom  in  8  ROM byte, valid one cycle after addr
tx_data  out  8  byte to UART
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART accepts the byte when tx_valid && tx_ready
rsp_valid  in  1  one-cycle strobe from the response parser
rsp_code  in  3  response code: 1 OK, 2 +CMPS, 3 ERROR, 4 new-SMS (+CMTI)
init_done  out  1  high while in READY/read phase
busy  out  1  high in any state other than IDLE, READY or FAIL
err  out  1  sticky; high in FAIL
err_idx  out  CIDX_W  table index that failed

Behaviour:
- Reset values: all outputs 0; state IDLE; retry count 0; timer 0.
- IDLE: on start, set cmd_idx=0 and go to LOAD. start is ignored in every other state.
- LOAD: latch base=desc_base, len=desc_len, exp=desc_rsp; set addr=desc_base, byte count=0; go to FETCH.
- FETCH: one wait cycle for ROM latency. Next cycle, tx_data<=rom and tx_valid<=1; go to SEND.
- SEND: hold tx_data and tx_valid stable until handshake.
  - On handshake: count+1, addr+1. If count==len, clear tx_valid, clear timer, go to WAIT; otherwise go to FETCH.
  - Throughput: at most one byte per 2 cycles.
- WAIT: timer increments every cycle.
  - rsp_valid with rsp_code==exp: clear retry; cmd_idx+1. If new cmd_idx==NUM_CMDS-1, go to READY; otherwise go to LOAD.
  - rsp_code==3, or timer reaches TIMEOUT_CYC-1: if retry==MAX_RETRY, go to FAIL; otherwise retry+1 and go to LOAD, which resends the whole command.
  - Any other code: ignored.
  - Expected code and timeout in the same cycle: the response wins.
- READY: init_done=1.
  - rsp_valid && rsp_code==4: cmd_idx=NUM_CMDS-1, go to LOAD. The read command is flagged as rd_mode.
  - After its bytes are sent, rd_mode goes to ARG instead of WAIT.
- ARG: send the msg_no byte(s) per the optional feature, then CR (8'h0D), each on the same SEND handshake; then go to WAIT.
  - In rd_mode, WAIT expects desc_rsp of entry NUM_CMDS-1.
  - Success returns to READY with cmd_idx=NUM_CMDS-1.
  - msg_no is sampled once on entry to ARG.
- Notifications while the read is in flight: rsp_code==4 is ignored outside READY. No queueing.
- FAIL: err=1, err_idx=failing index, tx_valid=0. Held until reset. init_done stays as it was.
- Reset mid-operation: all state and outputs return to reset values immediately. A partially sent command is abandoned.
- Counters: the byte counter is LEN_W bits; the timer is $clog2(TIMEOUT_CYC) bits and saturates. addr wraps modulo 2^ADDR_W and is not checked.

Optional Feature:
MSG_ASCII_EN
- Defined: msg_no is sent as ASCII decimal with no leading zeros, 1 to 3 digits.
  - Conversion is sequential subtraction, one digit per ARG cycle group.
  - Examples: 7 -> "7"; 42 -> "4","2"; 255 -> "2","5","5".
- Undefined: the single raw msg_no byte is sent unchanged, then CR.

Test Plan:
1. NUM_CMDS=4, lengths 23/11/10, responses 2/1/1, all answered.
   - Expect 44 TX bytes whose values equal the ROM contents in order.
   - Then init_done=1, busy=0, err=0.
2. Command 1 gets no response, TIMEOUT_CYC=16.
   - Expect an 11-byte resend starting 16 cycles after the last byte; OK on the second try then proceeds.
3. Command 0 answered with ERROR (code 3) three times, MAX_RETRY=2.
   - Expect FAIL, err=1, err_idx=0, tx_valid=0, and no further TX.
4. In READY, rsp_code=4 with msg_no=42.
   - With MSG_ASCII_EN: read-command bytes, then 0x34, 0x32, 0x0D.
   - Without it: read-command bytes, then 0x2A, 0x0D.
   - OK returns to READY.
5. Hold tx_ready low for 10 cycles during SEND.
   - tx_data and tx_valid stay stable; no byte is lost or duplicated.
6. Assert rst low mid-SEND of command 2.
   - All outputs go to 0 asynchronously.
   - After release, a new start re-runs from cmd_idx=0.

Source files
------------

// File: rtl/at_cmd_sequencer.sv
// AT command sequencer: streams table-driven commands from ROM to the UART and waits for replies.
// Optional MSG_ASCII_EN sends msg_no as ASCII decimal; otherwise the raw byte is sent.
module at_cmd_sequencer #(
  parameter int unsigned NUM_CMDS    = 4,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned LEN_W       = 6,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned CIDX_W      = $clog2(NUM_CMDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        msg_no,
  output logic [CIDX_W-1:0] cmd_idx,
  input  logic [ADDR_W-1:0] desc_base,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic [2:0]        desc_rsp,
  output logic [ADDR_W-1:0] addr,
  input  logic [7:0]        rom,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic              rsp_valid,
  input  logic [2:0]        rsp_code,
  output logic              init_done,
  output logic              busy,
  output logic              err,
  output logic [CIDX_W-1:0] err_idx
);

  localparam int unsigned TmrW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TmrW-1:0]   TmrLast = TmrW'(TIMEOUT_CYC - 1);
  localparam logic [TmrW-1:0]   TmrMax  = '1;
  localparam logic [RtyW-1:0]   RtyMax  = RtyW'(MAX_RETRY);
  localparam logic [CIDX_W-1:0] ReadIdx = CIDX_W'(NUM_CMDS - 1);
  localparam logic [2:0]        RspErr  = 3'd3;
  localparam logic [2:0]        RspSms  = 3'd4;
  localparam logic [7:0]        Cr      = 8'h0D;
  localparam logic [1:0]        ArgCr   = 2'd3;
`ifdef MSG_ASCII_EN
  localparam logic [1:0]        ArgFirst = 2'd2;
`else
  localparam logic [1:0]        ArgFirst = 2'd0;
`endif

  typedef enum logic [2:0] {
    StIdle, StLoad, StFetch, StSend, StWait, StReady, StArg, StFail
  } state_e;

  state_e            state_q, state_d;
  logic [CIDX_W-1:0] cmd_idx_q, cmd_idx_d, err_idx_q, err_idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [2:0]        exp_q, exp_d;
  logic [7:0]        tx_data_q, tx_data_d, rem_q, rem_d;
  logic              tx_valid_q, tx_valid_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic [RtyW-1:0]   retry_q, retry_d;
  logic              rd_mode_q, rd_mode_d, in_arg_q, in_arg_d, arg_last_q, arg_last_d;
  logic [1:0]        arg_pos_q, arg_pos_d;
  logic              fetch_ph_q, fetch_ph_d;
  logic              init_done_q, init_done_d, err_q, err_d;
  logic [LEN_W-1:0]  cnt_inc;
  logic [CIDX_W-1:0] cmd_inc;
`ifdef MSG_ASCII_EN
  logic [3:0]        digit_q, digit_d;
  logic              started_q, started_d;
  logic [7:0]        weight;
  assign weight = (arg_pos_q == 2'd2) ? 8'd100 : 8'd10;
`endif

  assign cnt_inc = cnt_q + 1'b1;
  assign cmd_inc = cmd_idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      cmd_idx_q   <= '0;
      err_idx_q   <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      exp_q       <= '0;
      tx_data_q   <= '0;
      rem_q       <= '0;
      tx_valid_q  <= 1'b0;
      timer_q     <= '0;
      retry_q     <= '0;
      rd_mode_q   <= 1'b0;
      in_arg_q    <= 1'b0;
      arg_last_q  <= 1'b0;
      arg_pos_q   <= '0;
      fetch_ph_q  <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef MSG_ASCII_EN
      digit_q     <= '0;
      started_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_idx_q   <= cmd_idx_d;
      err_idx_q   <= err_idx_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      tx_data_q   <= tx_data_d;
      rem_q       <= rem_d;
      tx_valid_q  <= tx_valid_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      rd_mode_q   <= rd_mode_d;
      in_arg_q    <= in_arg_d;
      arg_last_q  <= arg_last_d;
      arg_pos_q   <= arg_pos_d;
      fetch_ph_q  <= fetch_ph_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
`ifdef MSG_ASCII_EN
      digit_q     <= digit_d;
      started_q   <= started_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_idx_d   = cmd_idx_q;
    err_idx_d   = err_idx_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    tx_data_d   = tx_data_q;
    rem_d       = rem_q;
    tx_valid_d  = tx_valid_q;
    timer_d     = timer_q;
    retry_d     = retry_q;
    rd_mode_d   = rd_mode_q;
    in_arg_d    = in_arg_q;
    arg_last_d  = arg_last_q;
    arg_pos_d   = arg_pos_q;
    fetch_ph_d  = fetch_ph_q;
    init_done_d = init_done_q;
    err_d       = err_q;
`ifdef MSG_ASCII_EN
    digit_d     = digit_q;
    started_d   = started_q;
`endif
    case (state_q)
      StIdle: if (start) begin
        cmd_idx_d = '0;
        state_d   = StLoad;
      end
      StLoad: begin
        addr_d     = desc_base;
        len_d      = desc_len;
        exp_d      = desc_rsp;
        cnt_d      = '0;
        in_arg_d   = 1'b0;
        arg_last_d = 1'b0;
        state_d    = StFetch;
      end
      // ROM output is registered, so wait one cycle after addr settles before capturing it
      StFetch: if (!fetch_ph_q) begin
        fetch_ph_d = 1'b1;
      end else begin
        fetch_ph_d = 1'b0;
        tx_data_d  = rom;
        tx_valid_d = 1'b1;
        state_d    = StSend;
      end
      StSend: if (tx_ready) begin
        tx_valid_d = 1'b0;
        if (in_arg_q) begin
          if (arg_last_q) begin
            timer_d = '0;
            state_d = StWait;
          end else begin
            state_d = StArg;
          end
        end else begin
          cnt_d  = cnt_inc;
          addr_d = addr_q + 1'b1;
          if (cnt_inc != len_q) begin
            state_d = StFetch;
          end else if (rd_mode_q) begin
            in_arg_d  = 1'b1;
            rem_d     = msg_no;
            arg_pos_d = ArgFirst;
`ifdef MSG_ASCII_EN
            digit_d   = '0;
            started_d = 1'b0;
`endif
            state_d   = StArg;
          end else begin
            timer_d = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        timer_d = (timer_q == TmrMax) ? timer_q : timer_q + 1'b1;
        if (rsp_valid && rsp_code == exp_q) begin
          retry_d = '0;
          if (rd_mode_q) begin
            rd_mode_d = 1'b0;
            state_d   = StReady;
          end else begin
            cmd_idx_d = cmd_inc;
            if (cmd_inc == ReadIdx) begin
              init_done_d = 1'b1;
              state_d     = StReady;
            end else begin
              state_d = StLoad;
            end
          end
        end else if ((rsp_valid && rsp_code == RspErr) || timer_q == TmrLast) begin
          if (retry_q == RtyMax) begin
            err_d     = 1'b1;
            err_idx_d = cmd_idx_q;
            state_d   = StFail;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      StReady: if (rsp_valid && rsp_code == RspSms) begin
        cmd_idx_d = ReadIdx;
        rd_mode_d = 1'b1;
        state_d   = StLoad;
      end
      StArg: begin
`ifdef MSG_ASCII_EN
        // Each digit is found by repeated subtraction; leading zeros are skipped
        if (arg_pos_q == ArgCr) begin
          tx_data_d  = Cr;
          arg_last_d = 1'b1;
          tx_valid_d = 1'b1;
          state_d    = StSend;
        end else if (arg_pos_q != 2'd0 && rem_q >= weight) begin
          rem_d   = rem_q - weight;
          digit_d = digit_q + 1'b1;
        end else begin
          digit_d   = '0;
          arg_pos_d = (arg_pos_q == 2'd0) ? ArgCr : arg_pos_q - 1'b1;
          if (arg_pos_q == 2'd0 || digit_q != '0 || started_q) begin
            tx_data_d  = 8'h30 + ((arg_pos_q == 2'd0) ? rem_q : {4'd0, digit_q});
            started_d  = 1'b1;
            tx_valid_d = 1'b1;
            state_d    = StSend;
          end
        end
`else
        if (arg_pos_q == ArgCr) begin
          tx_data_d  = Cr;
          arg_last_d = 1'b1;
        end else begin
          tx_data_d = rem_q;
          arg_pos_d = ArgCr;
        end
        tx_valid_d = 1'b1;
        state_d    = StSend;
`endif
      end
      StFail: tx_valid_d = 1'b0;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = !(state_q inside {StIdle, StReady, StFail});
    cmd_idx   = cmd_idx_q;
    addr      = addr_q;
    tx_data   = tx_data_q;
    tx_valid  = tx_valid_q;
    init_done = init_done_q;
    err       = err_q;
    err_idx   = err_idx_q;
  end

endmodule

// File: tb/tb_at_cmd_sequencer.sv
// Directed/randomized bench for at_cmd_sequencer with a byte-stream reference model.
module tb_at_cmd_sequencer;
  localparam int unsigned AddrW = 7;
  localparam int unsigned LenW  = 6;
  localparam int unsigned TimeoutCyc = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       msg_no = 8'd0;
  logic [1:0]       cmd_idx, err_idx;
  logic [AddrW-1:0] desc_base, addr;
  logic [LenW-1:0]  desc_len;
  logic [2:0]       desc_rsp;
  logic [7:0]       rom = 8'd0;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b1;
  logic             rsp_valid = 1'b0;
  logic [2:0]       rsp_code = 3'd0;
  logic             init_done, busy, err;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [7:0] mem [128];
  int base_t [4] = '{0, 23, 34, 44};
  int len_t  [4] = '{23, 11, 10, 8};
  int rsp_t  [4] = '{2, 1, 1, 1};
  logic [7:0] got[$];
  int         got_t[$];
  logic [7:0] expq[$];

  at_cmd_sequencer #(
    .NUM_CMDS(4), .ADDR_W(AddrW), .LEN_W(LenW), .TIMEOUT_CYC(TimeoutCyc), .MAX_RETRY(2),
    .CIDX_W(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .msg_no(msg_no), .cmd_idx(cmd_idx),
    .desc_base(desc_base), .desc_len(desc_len), .desc_rsp(desc_rsp), .addr(addr), .rom(rom),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rsp_valid(rsp_valid),
    .rsp_code(rsp_code), .init_done(init_done), .busy(busy), .err(err), .err_idx(err_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom <= mem[addr];

  always_comb begin
    desc_base = AddrW'(base_t[cmd_idx]);
    desc_len  = LenW'(len_t[cmd_idx]);
    desc_rsp  = 3'(rsp_t[cmd_idx]);
  end

  // Inputs only change just after posedge, so a negedge sample sees the coming handshake
  always @(negedge clk) if (tx_valid && tx_ready) begin
    got.push_back(tx_data);
    got_t.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_bytes(input int n);
    int b = 0;
    while (got.size() < n && b < 3000) begin
      tick();
      b++;
    end
    chk($sformatf("bytes_%0d", n), got.size(), n);
  endtask

  task automatic wait_valid();
    int b = 0;
    while (!tx_valid && b < 20) begin
      tick();
      b++;
    end
    chk("tx_valid_seen", tx_valid, 1);
  endtask

  task automatic pulse_rsp(input logic [2:0] code);
    rsp_code  = code;
    rsp_valid = 1'b1;
    tick();
    rsp_valid = 1'b0;
    rsp_code  = 3'd0;
  endtask

  task automatic add_cmd(input int k);
    for (int i = 0; i < len_t[k]; i++) expq.push_back(mem[base_t[k] + i]);
  endtask

  task automatic add_arg(input int n);
`ifdef MSG_ASCII_EN
    string s = $sformatf("%0d", n);
    for (int i = 0; i < s.len(); i++) expq.push_back(s[i]);
`else
    expq.push_back(n[7:0]);
`endif
    expq.push_back(8'h0D);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), got[i], expq[i]);
    got.delete();
    got_t.delete();
    expq.delete();
  endtask

  initial begin
    logic [7:0] hold;
    int gap;
    int vals [4];
    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    vals[0] = 42; vals[1] = 7; vals[2] = 255; vals[3] = int'($urandom_range(0, 255));

    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_addr", addr, 0);
    chk("rst_cmd_idx", cmd_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_err", err, 0);
    chk("rst_err_idx", err_idx, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Full init with one timeout on command 1 and a stall during command 0
    start = 1'b1; tick(); start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_cmd_idx", cmd_idx, 0);
    wait_bytes(5);
    tx_ready = 1'b0;
    wait_valid();
    hold = tx_data;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("stall_valid_%0d", i), tx_valid, 1);
      chk($sformatf("stall_data_%0d", i), tx_data, hold);
    end
    tx_ready = 1'b1;
    wait_bytes(23);
    repeat (2) tick();
    pulse_rsp(3'd1);
    pulse_rsp(3'd4);
    repeat (2) tick();
    chk("ignored_codes_idx", cmd_idx, 0);
    pulse_rsp(3'd2);
    wait_bytes(34);
    gap = got_t[33];
    wait_bytes(45);
    gap = got_t[34] - gap;
    chk("resend_gap_in_window", (gap >= TimeoutCyc && gap <= TimeoutCyc + 6), 1);
    chk("resend_cmd_idx", cmd_idx, 1);
    repeat (2) tick();
    pulse_rsp(3'd1);
    wait_bytes(55);
    repeat (2) tick();
    pulse_rsp(3'd1);
    tick();
    chk("ready_init_done", init_done, 1);
    chk("ready_busy", busy, 0);
    chk("ready_err", err, 0);
    chk("ready_cmd_idx", cmd_idx, 3);
    chk("ready_tx_valid", tx_valid, 0);
    add_cmd(0); add_cmd(1); add_cmd(1); add_cmd(2);
    cmp_stream("init");
    start = 1'b1; tick(); start = 1'b0; tick();
    chk("start_ignored_ready", busy, 0);

    // New-SMS reads
    for (int v = 0; v < 4; v++) begin
      msg_no = vals[v][7:0];
      pulse_rsp(3'd4);
      tick();
      chk($sformatf("rd%0d_busy", v), busy, 1);
      chk($sformatf("rd%0d_idx", v), cmd_idx, 3);
      add_cmd(3);
      add_arg(vals[v]);
      wait_bytes(len_t[3] + 1);
      msg_no = ~vals[v][7:0];
      wait_bytes(expq.size());
      pulse_rsp(3'd4);
      tick();
      chk($sformatf("rd%0d_wait_busy", v), busy, 1);
      pulse_rsp(3'd1);
      tick();
      chk($sformatf("rd%0d_done_busy", v), busy, 0);
      chk($sformatf("rd%0d_init_done", v), init_done, 1);
      chk($sformatf("rd%0d_done_idx", v), cmd_idx, 3);
      cmp_stream($sformatf("rd%0d", v));
    end

    // Reset in the middle of command 2
    rst = 1'b0; tick(); rst = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_bytes(23); repeat (2) tick(); pulse_rsp(3'd2);
    wait_bytes(34); repeat (2) tick(); pulse_rsp(3'd1);
    wait_bytes(37);
    tx_ready = 1'b0;
    wait_valid();
    #2 rst = 1'b0;
    #1;
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_data", tx_data, 0);
    chk("arst_addr", addr, 0);
    chk("arst_cmd_idx", cmd_idx, 0);
    chk("arst_busy", busy, 0);
    chk("arst_init_done", init_done, 0);
    chk("arst_err", err, 0);
    tick();
    rst = 1'b1;
    tx_ready = 1'b1;
    got.delete(); got_t.delete();
    tick();

    // Re-run: command 0 rejected with ERROR until retries are exhausted
    start = 1'b1; tick(); start = 1'b0;
    chk("rerun_cmd_idx", cmd_idx, 0);
    chk("rerun_busy", busy, 1);
    for (int r = 1; r <= 3; r++) begin
      wait_bytes(23 * r);
      repeat (2) tick();
      pulse_rsp(3'd3);
    end
    tick();
    chk("fail_err", err, 1);
    chk("fail_err_idx", err_idx, 0);
    chk("fail_tx_valid", tx_valid, 0);
    chk("fail_busy", busy, 0);
    chk("fail_init_done", init_done, 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (40) tick();
    chk("fail_no_more_tx", got.size(), 69);
    chk("fail_err_held", err, 1);
    add_cmd(0); add_cmd(0); add_cmd(0);
    cmp_stream("retry");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
